// File: rtl/flick_conditioner_if.sv
// ============================================================================
// Module  : flick_conditioner_if
// Purpose : Button-side and flasher-side signals of the flick conditioner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface flick_conditioner_if;
   logic       flick_raw;
   logic       flick_pulse;
   logic       flick_level;
   logic [7:0] press_count;

   modport master (
      output flick_raw,
      input  flick_pulse,
      input  flick_level,
      input  press_count
   );

   modport slave (
      input  flick_raw,
      output flick_pulse,
      output flick_level,
      output press_count
   );
endinterface

`default_nettype wire

// File: rtl/flick_conditioner.sv
// ============================================================================
// Module  : flick_conditioner
// Purpose : Synchronises and debounces the flick button into a one-cycle pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flick_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic                clk,
   input  logic                rst,
   flick_conditioner_if.slave  flick_if
);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_PRESS_CHK   = 2'd1,
      S_HELD        = 2'd2,
      S_RELEASE_CHK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]       c_cnt_max  = 8'hFF;

   logic [SYNC_STAGES-1:0] sync_q;
   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   pulse_q;
   logic                   level_q;
   logic [7:0]             count_q;
   logic                   w_sync;

   assign w_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
         count_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], flick_if.flick_raw};
         pulse_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               level_q <= 1'b0;
               if (w_sync) begin
                  state_q <= S_PRESS_CHK;
                  cnt_q   <= '0;
               end
            end
            S_PRESS_CHK: begin
               // Any low sample inside the window rejects the press as bounce.
               if (!w_sync) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == c_cnt_last) begin
                  state_q <= S_HELD;
                  pulse_q <= 1'b1;
                  level_q <= 1'b1;
                  if (count_q != c_cnt_max) begin
                     count_q <= count_q + 8'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_HELD: begin
               if (!w_sync) begin
                  state_q <= S_RELEASE_CHK;
                  cnt_q   <= '0;
               end
            end
            S_RELEASE_CHK: begin
               if (w_sync) begin
                  state_q <= S_HELD;
               end else if (cnt_q == c_cnt_last) begin
                  state_q <= S_IDLE;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign flick_if.flick_pulse = pulse_q;
   assign flick_if.flick_level = level_q;
   assign flick_if.press_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_flick_conditioner.sv
// ============================================================================
// Module  : tb_flick_conditioner
// Purpose : Directed scoreboard bench for the flick conditioner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flick_conditioner;

   typedef struct {
      int edge_n;
      int cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   logic prev_level = 1'b0;
   int   m_count = 0;

   exp_t pulse_q[$];
   int   fall_q[$];

   flick_conditioner_if flick_if ();

   flick_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (16),
      .CNT_W           (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flick_if (flick_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      vectors = vectors + 1;
      if (act !== exp_v) begin
         miscompares = miscompares + 1;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp_v);
      end
   endtask

   task automatic hold(input logic v, input int n);
      flick_if.flick_raw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic push_press(input int t0, input int high_len);
      exp_t e;
      m_count = (m_count < 255) ? m_count + 1 : 255;
      e.edge_n = t0 + 18;
      e.cnt    = m_count;
      pulse_q.push_back(e);
      fall_q.push_back(t0 + high_len + 18);
   endtask

   // Scoreboard monitor: every pulse and every level fall must match a queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (flick_if.flick_pulse) begin
            if (pulse_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               e = pulse_q.pop_front();
               chk("pulse_edge", cyc, e.edge_n);
               chk("pulse_count", int'(flick_if.press_count), e.cnt);
               chk("pulse_level", int'(flick_if.flick_level), 1);
            end
         end
         if (prev_level && !flick_if.flick_level) begin
            if (fall_q.size() == 0) begin
               chk("unexpected_level_fall", 1, 0);
            end else begin
               chk("level_fall_edge", cyc, fall_q.pop_front());
            end
         end
         if (!prev_level && flick_if.flick_level && !flick_if.flick_pulse) begin
            chk("level_rise_without_pulse", 1, 0);
         end
         prev_level = flick_if.flick_level;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t0;
      flick_if.flick_raw = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pulse", int'(flick_if.flick_pulse), 0);
      chk("reset_level", int'(flick_if.flick_level), 0);
      chk("reset_count", int'(flick_if.press_count), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      hold(1'b0, 5);

      // Clean press: 40 high, 30 low
      t0 = cyc + 1;
      push_press(t0, 40);
      hold(1'b1, 40);
      hold(1'b0, 30);
      chk("clean_count", int'(flick_if.press_count), 1);

      // Bounce rejection
      for (int i = 0; i < 4; i++) begin
         hold(1'b1, 5);
         hold(1'b0, 3);
      end
      hold(1'b0, 30);
      chk("bounce_level", int'(flick_if.flick_level), 0);
      chk("bounce_count", int'(flick_if.press_count), 1);

      // Window edge: 16 samples rejected, 17 accepted
      hold(1'b1, 16);
      hold(1'b0, 30);
      chk("run16_count", int'(flick_if.press_count), 1);
      t0 = cyc + 1;
      push_press(t0, 17);
      hold(1'b1, 17);
      hold(1'b0, 30);
      chk("run17_count", int'(flick_if.press_count), 2);

      // Release bounce: low 10 inside the release window returns to HELD
      t0 = cyc + 1;
      m_count = m_count + 1;
      pulse_q.push_back('{t0 + 18, m_count});
      fall_q.push_back(t0 + 80 + 18);
      hold(1'b1, 40);
      hold(1'b0, 10);
      chk("release_bounce_level", int'(flick_if.flick_level), 1);
      hold(1'b1, 30);
      hold(1'b0, 30);
      chk("release_bounce_count", int'(flick_if.press_count), 3);

      // Reset mid-debounce at edges t0+10..t0+11
      t0 = cyc + 1;
      m_count = 1;
      pulse_q.push_back('{t0 + 30, 1});
      fall_q.push_back(t0 + 40 + 18);
      hold(1'b1, 10);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_pulse", int'(flick_if.flick_pulse), 0);
      chk("midrst_level", int'(flick_if.flick_level), 0);
      chk("midrst_count", int'(flick_if.press_count), 0);
      @(negedge clk);
      rst = 1'b0;
      hold(1'b1, 28);
      hold(1'b0, 30);
      chk("midrst_final_count", int'(flick_if.press_count), 1);

      // Saturation
      for (int k = 0; k < 260; k++) begin
         t0 = cyc + 1;
         push_press(t0, 17);
         hold(1'b1, 17);
         hold(1'b0, 20);
      end
      hold(1'b0, 10);
      chk("saturated_count", int'(flick_if.press_count), 255);

      // Reset on the edge the pulse would fire
      t0 = cyc + 1;
      hold(1'b1, 18);
      rst = 1'b1;
      @(negedge clk);
      chk("coinc_pulse", int'(flick_if.flick_pulse), 0);
      chk("coinc_count", int'(flick_if.press_count), 0);
      rst = 1'b0;
      m_count = 1;
      pulse_q.push_back('{t0 + 37, 1});
      fall_q.push_back(t0 + 40 + 18);
      hold(1'b1, 21);
      hold(1'b0, 30);
      chk("coinc_final_count", int'(flick_if.press_count), 1);

      chk("pulse_queue_empty", pulse_q.size(), 0);
      chk("fall_queue_empty", fall_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
